// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding, funct3 codes and request decode helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal funct3 codes differ between loads and stores.
  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B),
      (f3 == F3_H),
      (f3 == F3_W):  ok = 1'b1;
      (f3 == F3_BU),
      (f3 == F3_HU): ok = !we;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halves need an even address, words need a 4-byte aligned one.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (f3 == F3_H),
      (f3 == F3_HU): bad = off[0];
      (f3 == F3_W):  bad = (off != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_lane_align.sv
// Byte-lane steering between 32-bit memory words and sub-word accesses.
// Extracts and extends load lanes; merges store lanes into an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_word_o
);

  logic [31:0] b_sh;
  logic [31:0] h_sh;
  logic [31:0] mask;
  logic [31:0] rep;

  // Shift the addressed lane down, then sign- or zero-extend it.
  always_comb begin
    b_sh      = ld_word_i >> {off_i, 3'b000};
    h_sh      = ld_word_i >> {off_i[1], 4'b0000};
    ld_data_o = ld_word_i;
    unique case (1'b1)
      (funct3_i == F3_B):
        ld_data_o = {{24{b_sh[7]}}, b_sh[7:0]};
      (funct3_i == F3_BU):
        ld_data_o = {24'h0, b_sh[7:0]};
      (funct3_i == F3_H):
        ld_data_o = {{16{h_sh[15]}}, h_sh[15:0]};
      (funct3_i == F3_HU):
        ld_data_o = {16'h0, h_sh[15:0]};
      default:
        ld_data_o = ld_word_i;
    endcase
  end

  // Replicate store data across lanes and keep only the target lane.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    rep  = st_wdata_i;
    unique case (1'b1)
      (funct3_i == F3_B): begin
        mask = 32'h0000_00FF << {off_i, 3'b000};
        rep  = {4{st_wdata_i[7:0]}};
      end
      (funct3_i == F3_H): begin
        mask = 32'h0000_FFFF << {off_i[1], 4'b0000};
        rep  = {2{st_wdata_i[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        rep  = st_wdata_i;
      end
    endcase
    st_word_o = (st_old_i & ~mask) | (rep & mask);
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: RV32I sub-word accesses over a word-wide data memory.
// Sub-word stores use read-modify-write; responses are registered.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic        oor;
  logic        sub_word;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  lsu_lane_align u_align (
    .ld_word_i  (mem_rdata),
    .off_i      (addr_q[1:0]),
    .funct3_i   (f3_q),
    .ld_data_o  (ld_data),
    .st_old_i   (old_q),
    .st_wdata_i (wdata_q),
    .st_word_o  (st_word)
  );

  // Error decode of the request being accepted this cycle.
  always_comb begin
    oor      = (req_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0;
    req_err  = oor
             || !f3_legal(req_we, req_funct3)
             || misaligned(req_funct3, req_addr[1:0]);
    sub_word = (req_funct3 != F3_W);
  end

  // Main FSM with latched request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      old_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q <= S_LOAD;
            end else if (sub_word) begin
              state_q <= S_RMW_RD;
            end else begin
              state_q <= S_STORE;
            end
          end
        end
        S_LOAD: begin
          resp_rdata_q <= ld_data;
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_STORE: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_RMW_RD: begin
          old_q   <= mem_rdata;
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them at once.
  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_read  = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write = (state_q == S_STORE) || (state_q == S_RMW_WR);
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = 32'h0;
    unique case (state_q)
      S_STORE:  mem_wdata = wdata_q;
      S_RMW_WR: mem_wdata = st_word;
      default:  mem_wdata = 32'h0;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store unit between the pipeline MEM stage and the word-wide data memory.
- The data memory behaves as follows: 256 x 32-bit words; combinational read on addr[9:2]; whole-word write on posedge clk when mem_write is asserted.
- This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Byte and halfword stores use a two-cycle read-modify-write.
- It stalls the pipeline through busy and returns load data, or an error, through a registered response.

Parameters:
- MEM_WORDS_LOG2, 8, log2 of data-memory depth in words. Legal byte range is 0 .. 4*2^MEM_WORDS_LOG2-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; accepted when req_valid && !busy.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (load 000/001/010/100/101; store 000/001/010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from low bits.
- busy  out  1  unit occupied; pipeline must hold the request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3, or out of range.
- mem_addr  out  32  word-aligned address to data memory ({addr[31:2],2'b00}).
- mem_wdata  out  32  word to write.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, resp_valid, resp_err, mem_read and mem_write are all 0.
  - resp_rdata=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts immediately. mem_write drops combinationally with state, so no partial or RMW write commits after reset asserts.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- Accept (in IDLE with req_valid):
  - Latch we, funct3, addr and wdata.
  - Decode on the latched fields:
    - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
    - Illegal funct3.
    - Out of range: addr >> 2 >= 2^MEM_WORDS_LOG2.
  - On error: stay in IDLE, no memory access; next cycle resp_valid=1, resp_err=1, resp_rdata=0.
  - Else go to LOAD (load), STORE (SW) or RMW_RD (SB/SH).
- LOAD (1 cycle):
  - mem_read=1.
  - At the edge, register the selected lane into resp_rdata. Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Return to IDLE with resp_valid=1 for one cycle.
  - Total latency: response 2 cycles after the acceptance edge.
- STORE (1 cycle): mem_write=1, mem_wdata=req_wdata. Then IDLE with resp_valid=1, resp_rdata=0.
- RMW_RD (1 cycle): mem_read=1; capture mem_rdata into the merge register.
- RMW_WR (1 cycle):
  - mem_write=1.
  - mem_wdata = captured word with the target byte (SB) or half (SH) replaced by req_wdata[7:0] / req_wdata[15:0].
  - Then IDLE with resp_valid=1.
- Strobes and address:
  - busy = (state != IDLE).
  - mem_read and mem_write are never both 1.
  - mem_addr holds the latched word address in every non-IDLE state.
- resp_valid is a single-cycle pulse. A new request may be accepted in the same cycle resp_valid is high, so back-to-back operation is allowed.
- Requests arriving while busy are ignored. The pipeline holds them stable.
- Address 0 and the last legal word (4*2^MEM_WORDS_LOG2-4) are valid. The next word address is out of range.

Decomposition:
- Package lsu_pkg:
  - State enum.
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module lsu_lane_align (combinational):
  - Load extract/extend: word, addr[1:0], funct3 -> rdata.
  - Store merge: old word, wdata, addr[1:0], funct3 -> merged word.

Test Plan:
- LW at 0x0000_0010 with memory word 4 = 0xDEADBEEF -> busy for 1 cycle; resp_valid 2 cycles after accept; resp_rdata=0xDEADBEEF; resp_err=0.
- LB at 0x13 / LBU at 0x13, word 4 = 0x80123456 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB 0xAB at 0x11 with word 4 = 0x11223344 -> RMW_RD then RMW_WR; memory word 4 = 0x1122AB44; resp_valid 3 cycles after accept.
- LH at 0x0000_0003, SW at 0x0000_0002, and LW at 0x0000_0400 (MEM_WORDS_LOG2=8) -> each gives resp_err=1 one cycle after accept, with no mem_read or mem_write pulse.
- Drop rst_n during RMW_WR of SH 0xBEEF at 0x8 (word = 0x01020304) -> mem_write drops immediately; word 2 stays 0x01020304; busy=0; resp_valid=0.
- Back-to-back SW 0x55AA55AA at 0x20 then LW at 0x20 with req_valid held -> second request accepted in the first response cycle; load returns 0x55AA55AA.
